// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that shares one boothsmult among NUM_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a WAIT watchdog that drives the sticky error flag.
`ifndef N_BIT
`define N_BIT 8
`endif

module mult_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned W              = `N_BIT,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                 Clock,
   input  logic                 nReset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*W-1:0] op1_bus,
   input  logic [NUM_REQ*W-1:0] op2_bus,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   valid,
   output logic [2*W-1:0]       result,
   output logic                 busy,
   output logic                 error,
   output logic [W-1:0]         mult_op1,
   output logic [W-1:0]         mult_op2,
   output logic                 mult_request,
   input  logic [2*W-1:0]       mult_result,
   input  logic                 mult_done
);
   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {StIdle, StIssue, StGuard, StWait, StResp} state_e;

   state_e               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [PW-1:0]        idx_q, idx_d;
   logic [PW-1:0]        pick;
   logic                 found;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [W-1:0]         op1_q, op1_d;
   logic [W-1:0]         op2_q, op2_d;
   logic [2*W-1:0]       result_q, result_d;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 error_q, error_d;
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   // First set request at or after ptr, wrapping around.
   always_comb begin
      int cand;
      cand  = 0;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         cand = (int'(ptr_q) + i) % int'(NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = PW'(cand);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      grant_d  = grant_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      result_d = result_q;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      error_d  = error_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d       = StIssue;
               idx_d         = pick;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               op1_d         = op1_bus[pick*W +: W];
               op2_d         = op2_bus[pick*W +: W];
            end
         end
         StIssue: state_d = StGuard;
         StGuard: begin
            // Done may still be high from the previous operation; skip it.
            state_d = StWait;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         StWait: begin
            if (mult_done) begin
               result_d = mult_result;
               state_d  = StResp;
            end
`ifdef MULT_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               result_d = '0;
               error_d  = 1'b1;
               state_d  = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         StResp: begin
            state_d = StIdle;
            grant_d = '0;
            ptr_d   = (idx_q == PW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         idx_q    <= '0;
         grant_q  <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         result_q <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         error_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         grant_q  <= grant_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         result_q <= result_d;
`ifdef MULT_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         error_q  <= error_d;
`endif
      end
   end

   assign grant        = grant_q;
   assign valid        = (state_q == StResp) ? grant_q : '0;
   assign result       = result_q;
   assign busy         = (state_q != StIdle);
   assign mult_request = (state_q == StIssue);
   assign mult_op1     = op1_q;
   assign mult_op2     = op2_q;

endmodule
